kernel3_gmem_b_s_axi_rd_resp: RTL

KERNEL3_GMEM_B_S_AXI_RD_RESP -- requirements
Module: kernel3_gmem_B_s_axi_rd_resp

---
 rtl/kernel3_gmem_b_s_axi_rd_resp.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/kernel3_gmem_b_s_axi_rd_resp.sv
// AXI4 read responder for the gmem_B port: queues AR requests and streams INCR
// bursts out of a backdoor-preloaded synchronous word memory.
module kernel3_gmem_b_s_axi_rd_resp #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 12,
  parameter  int ARQ_DEPTH  = 4,
  localparam int ADDR_LSB   = $clog2(DATA_WIDTH / 8),
  localparam int WORD_AW    = ADDR_WIDTH - ADDR_LSB
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  input  logic                  mem_we,
  input  logic [WORD_AW-1:0]    mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  localparam int MEM_WORDS = 2 ** WORD_AW;
  localparam int PTR_W     = $clog2(ARQ_DEPTH);
  localparam int CNT_W     = $clog2(ARQ_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  // Handshakes: a transfer happens on a rising edge where clk_en, valid and
  // ready are all 1; valid never waits for ready, and payload holds while stalled.
  state_e                state_q, state_d;
  logic [WORD_AW-1:0]    q_addr [ARQ_DEPTH];
  logic [7:0]            q_len  [ARQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  arready_q;
  logic [WORD_AW-1:0]    waddr_q, waddr_d, rd_addr;
  logic [7:0]            len_q, len_d, beat_q, beat_d;
  logic                  rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic                  push, pop, rd_en, q_empty;

  assign push    = clk_en && s_arvalid && arready_q && !reset;
  assign q_empty = (count_q == '0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    rd_en   = 1'b0;
    rd_addr = waddr_q;
    waddr_d = waddr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    rlast_d = rlast_q;
    if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!q_empty) begin
            pop     = 1'b1;
            waddr_d = q_addr[rd_ptr_q];
            len_d   = q_len[rd_ptr_q];
            beat_d  = 8'd0;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          rd_en   = 1'b1;
          rlast_d = (len_q == 8'd0);
          state_d = ST_BURST;
        end
        ST_BURST: begin
          if (s_rready) begin
            if (!rlast_q) begin
              waddr_d = waddr_q + 1'b1;
              rd_addr = waddr_q + 1'b1;
              rd_en   = 1'b1;
              beat_d  = beat_q + 8'd1;
              rlast_d = ((beat_q + 8'd1) == len_q);
            end else begin
              rlast_d = 1'b0;
              if (!q_empty) begin
                pop     = 1'b1;
                waddr_d = q_addr[rd_ptr_q];
                len_d   = q_len[rd_ptr_q];
                beat_d  = 8'd0;
                state_d = ST_LOAD;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      arready_q <= 1'b1;
      waddr_q   <= '0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else if (clk_en) begin
      state_q   <= state_d;
      count_q   <= count_d;
      arready_q <= (count_d != CNT_W'(ARQ_DEPTH));
      waddr_q   <= waddr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      rlast_q   <= rlast_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(ARQ_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(ARQ_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (rd_en) rdata_q <= mem[rd_addr];
    end
  end

  // Queue storage and memory are not reset; the byte offset is dropped on entry.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr_q] <= WORD_AW'(s_araddr >> ADDR_LSB);
      q_len[wr_ptr_q]  <= s_arlen;
    end
    if (clk_en && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign s_arready   = arready_q;
  assign s_rvalid    = (state_q == ST_BURST);
  assign s_rdata     = rdata_q;
  assign s_rlast     = rlast_q;
  assign s_rresp     = 2'b00;
  assign busy        = (state_q != ST_IDLE) || !q_empty;
  assign dbg_state_o = state_q;

endmodule
